matmul_controller: RTL

MATMUL_CONTROLLER -- requirements
Module: matmul_controller

---
 rtl/matmul_controller_if.sv | 43 ++++
 rtl/matmul_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/matmul_controller_if.sv
// Control/status bundle between the matmul sequencer and its environment
// (control register, datapath strobes, scratchpad write port).
interface matmul_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W   = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1;

  logic             start_bit_i;
  logic             mode_bit_i;
  logic [DIM_W-1:0] N_i;
  logic [DIM_W-1:0] K_i;
  logic [DIM_W-1:0] M_i;
  logic [1:0]       write_target_i;
  logic             sp_ready_i;

  logic             operand_valid_o;
  logic [DIM_W-1:0] operand_addr_o;
  logic             pe_clear_o;
  logic             sp_write_enable_o;
  logic [DIM_W-1:0] sp_row_o;
  logic [1:0]       sp_target_o;
  logic             busy_o;
  logic             done_o;
  logic             clear_start_o;
  logic [2:0]       state_o;

  // Scratchpad write: a row transfers on a rising edge where
  // sp_write_enable_o and sp_ready_i are both 1; while sp_ready_i is 0 the
  // controller keeps sp_write_enable_o and sp_row_o unchanged.
  modport master (
    input  start_bit_i, mode_bit_i, N_i, K_i, M_i, write_target_i, sp_ready_i,
    output operand_valid_o, operand_addr_o, pe_clear_o, sp_write_enable_o,
           sp_row_o, sp_target_o, busy_o, done_o, clear_start_o, state_o
  );

  modport slave (
    output start_bit_i, mode_bit_i, N_i, K_i, M_i, write_target_i, sp_ready_i,
    input  operand_valid_o, operand_addr_o, pe_clear_o, sp_write_enable_o,
           sp_row_o, sp_target_o, busy_o, done_o, clear_start_o, state_o
  );
endinterface

// File: rtl/matmul_controller.sv
// Sequencer for a systolic matmul: feeds K+1 operand slices, waits out the
// array skew, writes N+1 result rows to the scratchpad, then pulses done.
module matmul_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
) (
  input logic              clk_i,
  input logic              rst_i,
  matmul_controller_if.master bus
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W   = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DIM_W-1:0] ONE_D = 1;
  localparam logic [DIM_W:0]   ONE_C = 1;

  logic [2:0]       state;
  logic [DIM_W-1:0] lat_n;
  logic [DIM_W-1:0] lat_k;
  logic [DIM_W-1:0] lat_m;
  logic [DIM_W:0]   drain_cnt;
  logic             relaunch_hold;

  logic             operand_valid;
  logic [DIM_W-1:0] operand_addr;
  logic             pe_clear;
  logic             sp_we;
  logic [DIM_W-1:0] sp_row;
  logic [1:0]       sp_target;
  logic             busy;
  logic             done;
  logic             clear_start;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      lat_n         <= '0;
      lat_k         <= '0;
      lat_m         <= '0;
      drain_cnt     <= '0;
      relaunch_hold <= 1'b0;
      operand_valid <= 1'b0;
      operand_addr  <= '0;
      pe_clear      <= 1'b0;
      sp_we         <= 1'b0;
      sp_row        <= '0;
      sp_target     <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      clear_start   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // The start bit is still high in the first idle cycle after DONE
          // (the clear pulse lands in the register only then), so skip it.
          if (relaunch_hold) begin
            relaunch_hold <= 1'b0;
          end else if (bus.start_bit_i) begin
            lat_n         <= bus.N_i;
            lat_k         <= bus.K_i;
            lat_m         <= bus.M_i;
            sp_target     <= bus.write_target_i;
            operand_valid <= 1'b1;
            operand_addr  <= '0;
            pe_clear      <= ~bus.mode_bit_i;
            busy          <= 1'b1;
            state         <= S_FEED;
          end
        end
        S_FEED: begin
          pe_clear <= 1'b0;
          if (operand_addr == lat_k) begin
            operand_valid <= 1'b0;
            operand_addr  <= '0;
            // Down-counter loaded with N+M gives N+M+1 drain cycles.
            drain_cnt     <= {1'b0, lat_n} + {1'b0, lat_m};
            state         <= S_DRAIN;
          end else begin
            operand_addr <= operand_addr + ONE_D;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            sp_we  <= 1'b1;
            sp_row <= '0;
            state  <= S_WB;
          end else begin
            drain_cnt <= drain_cnt - ONE_C;
          end
        end
        S_WB: begin
          if (bus.sp_ready_i) begin
            if (sp_row == lat_n) begin
              sp_we       <= 1'b0;
              sp_row      <= '0;
              done        <= 1'b1;
              clear_start <= 1'b1;
              state       <= S_DONE;
            end else begin
              sp_row <= sp_row + ONE_D;
            end
          end
        end
        S_DONE: begin
          done          <= 1'b0;
          clear_start   <= 1'b0;
          busy          <= 1'b0;
          relaunch_hold <= 1'b1;
          state         <= S_IDLE;
        end
        default: begin
          operand_valid <= 1'b0;
          pe_clear      <= 1'b0;
          sp_we         <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          clear_start   <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.operand_valid_o   = operand_valid;
  assign bus.operand_addr_o    = operand_addr;
  assign bus.pe_clear_o        = pe_clear;
  assign bus.sp_write_enable_o = sp_we;
  assign bus.sp_row_o          = sp_row;
  assign bus.sp_target_o       = sp_target;
  assign bus.busy_o            = busy;
  assign bus.done_o            = done;
  assign bus.clear_start_o     = clear_start;
  assign bus.state_o           = state;
endmodule
